// File: rtl/legv8_multicycle_ctrl_pkg.sv
// Shared definitions for the LEGv8 multicycle control unit.
// Contents:
//   state_e   - control FSM states
//   OP_*      - opcode field values (R/D: instr[31:21], CB: instr[31:24], B: instr[31:26])
//   alu_op_e  - ALU operation codes driven on alu_op
//   IMM_*     - sign-extend format select, shared with the sign-extend unit
//   iclass_e / decode_t - result of the opcode decoder
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_LD,
    S_BRANCH,
    S_JUMP
  } state_e;

  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;
  localparam logic [5:0]  OP_B    = 6'b00_0101;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_AND    = 3'b010,
    ALU_ORR    = 3'b011,
    ALU_PASS_B = 3'b100
  } alu_op_e;

  localparam logic [1:0] IMM_B  = 2'b00;
  localparam logic [1:0] IMM_CB = 2'b10;
  localparam logic [1:0] IMM_D  = 2'b11;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_R,
    CLS_LDUR,
    CLS_STUR,
    CLS_CBZ,
    CLS_B
  } iclass_e;

  typedef struct packed {
    iclass_e    cls;
    alu_op_e    alu_op;
    logic [1:0] imm_sel;
    logic       legal;
  } decode_t;

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// Memory request/ready handshake between the control unit and the single
// memory port.
//   mem_req      - request valid, held until mem_ready is seen
//   mem_we       - 1 = write (STUR), 0 = read
//   mem_is_fetch - request addresses the PC (instruction fetch)
//   mem_ready    - memory completes the current request this cycle
interface legv8_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_is_fetch;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_is_fetch, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_is_fetch, output mem_ready);
endinterface

// File: rtl/legv8_multicycle_ctrl_opdecode.sv
// Combinational opcode decoder: classifies the instruction register and
// provides the ALU operation and sign-extend format for it.
//   instr - instruction-register contents
//   dec   - {class, alu_op, imm_sel, legal}
module legv8_opdecode
  import legv8_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);

  always_comb begin
    // NOTE: every field gets a default first so no path leaves it unassigned (no latch).
    dec.cls     = CLS_NONE;
    dec.alu_op  = ALU_ADD;
    dec.imm_sel = IMM_B;
    dec.legal   = 1'b0;

    // Opcode fields of different widths do not alias each other, so the
    // checks below are mutually exclusive.
    unique case (instr[31:21])
      OP_ADD:  begin dec.cls = CLS_R;    dec.alu_op = ALU_ADD; dec.legal = 1'b1; end
      OP_SUB:  begin dec.cls = CLS_R;    dec.alu_op = ALU_SUB; dec.legal = 1'b1; end
      OP_AND:  begin dec.cls = CLS_R;    dec.alu_op = ALU_AND; dec.legal = 1'b1; end
      OP_ORR:  begin dec.cls = CLS_R;    dec.alu_op = ALU_ORR; dec.legal = 1'b1; end
      OP_LDUR: begin dec.cls = CLS_LDUR; dec.imm_sel = IMM_D;  dec.legal = 1'b1; end
      OP_STUR: begin dec.cls = CLS_STUR; dec.imm_sel = IMM_D;  dec.legal = 1'b1; end
      default: begin
        if (instr[31:24] == OP_CBZ) begin
          dec.cls     = CLS_CBZ;
          dec.alu_op  = ALU_PASS_B;
          dec.imm_sel = IMM_CB;
          dec.legal   = 1'b1;
        end else if (instr[31:26] == OP_B) begin
          dec.cls     = CLS_B;
          dec.imm_sel = IMM_B;
          dec.legal   = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle control FSM for the LEGv8 core. Sequences fetch, decode,
// execute, memory and writeback over a shared ALU and one memory port,
// owns the memory handshake and its timeout.
//   clk, reset   - clock; synchronous active-high reset
//   instr        - instruction-register contents
//   alu_zero     - ALU zero flag, used in S_BRANCH
//   mem          - memory handshake (master side)
//   ir_write, pc_write, pc_src, imm_sel, alu_src, alu_op, reg2loc,
//   reg_write, mem_to_reg - datapath controls
//   illegal, fault - one-cycle error pulses; busy - not idling in S_FETCH
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    instr,
  input  logic                           alu_zero,
  legv8_multicycle_ctrl_if.master        mem,
  output logic                           ir_write,
  output logic                           pc_write,
  output logic                           pc_src,
  output logic [1:0]                     imm_sel,
  output logic                           alu_src,
  output logic [2:0]                     alu_op,
  output logic                           reg2loc,
  output logic                           reg_write,
  output logic                           mem_to_reg,
  output logic                           illegal,
  output logic                           fault,
  output logic                           busy
);

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(MEM_TIMEOUT);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    imm_sel_q, imm_sel_d;
  decode_t       dec;

  logic mem_req, mem_we, mem_is_fetch;
  logic waiting, timed_out;

  legv8_opdecode u_opdecode (
    .instr (instr),
    .dec   (dec)
  );

  // States that hold a memory request open.
  assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timed_out = (MEM_TIMEOUT != 0) && waiting && (timer_q == TO_LIMIT);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= S_FETCH;
      timer_q   <= '0;
      imm_sel_q <= IMM_B;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      imm_sel_q <= imm_sel_d;
    end
  end

  // Next-state logic and wait counter.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    if (waiting && timed_out) begin
      state_d = S_FETCH;
    end else if (waiting && !mem.mem_ready) begin
      if (MEM_TIMEOUT != 0) timer_d = timer_q + TW'(1);
    end else begin
      unique case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          unique case (dec.cls)
            CLS_R:              state_d = S_EXEC_R;
            CLS_LDUR, CLS_STUR: state_d = S_ADDR;
            CLS_CBZ:            state_d = S_BRANCH;
            CLS_B:              state_d = S_JUMP;
            default:            state_d = S_FETCH;
          endcase
        end
        S_EXEC_R: state_d = S_WB_R;
        S_ADDR:   state_d = (dec.cls == CLS_STUR) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: state_d = S_WB_LD;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // Output logic. Everything is forced low while reset is asserted so an
  // aborted transaction issues no request or write.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    imm_sel_d    = imm_sel_q;
    alu_src      = 1'b0;
    alu_op       = ALU_ADD;
    reg2loc      = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    illegal      = 1'b0;
    fault        = 1'b0;
    busy         = 1'b0;

    if (reset) begin
      imm_sel_d = IMM_B;
    end else begin
      busy  = (state_q != S_FETCH);
      fault = timed_out;
      unique case (state_q)
        S_FETCH: begin
          mem_req      = !timed_out;
          mem_is_fetch = !timed_out;
          if (!timed_out && mem.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          imm_sel_d = dec.imm_sel;
          // Register read happens here, so Rt must already be selected.
          reg2loc   = (dec.cls == CLS_STUR) || (dec.cls == CLS_CBZ);
          illegal   = !dec.legal;
        end
        S_EXEC_R: alu_op = dec.alu_op;
        S_WB_R:   reg_write = 1'b1;
        S_ADDR: begin
          alu_src   = 1'b1;
          imm_sel_d = IMM_D;
          reg2loc   = (dec.cls == CLS_STUR);
        end
        S_MEM_RD: mem_req = !timed_out;
        S_MEM_WR: begin
          mem_req = !timed_out;
          mem_we  = !timed_out;
        end
        S_WB_LD: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          reg2loc   = 1'b1;
          alu_op    = ALU_PASS_B;
          imm_sel_d = IMM_CB;
          pc_write  = alu_zero;
          pc_src    = alu_zero;
        end
        S_JUMP: begin
          imm_sel_d = IMM_B;
          pc_write  = 1'b1;
          pc_src    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imm_sel          = imm_sel_d;
  assign mem.mem_req      = mem_req;
  assign mem.mem_we       = mem_we;
  assign mem.mem_is_fetch = mem_is_fetch;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
module tb_legv8_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        alu_zero;
  logic        ir_write, pc_write, pc_src, alu_src, reg2loc;
  logic        reg_write, mem_to_reg, illegal, fault, busy;
  logic [1:0]  imm_sel;
  logic [2:0]  alu_op;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADD  = 32'h8B03_0041;
  localparam logic [31:0] I_LDUR = 32'hF840_8041;
  localparam logic [31:0] I_STUR = 32'hF800_0041;
  localparam logic [31:0] I_CBZ  = 32'hB400_0060;
  localparam logic [31:0] I_B    = 32'h1400_0002;
  localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

  legv8_multicycle_ctrl_if mem_bus ();

  legv8_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .alu_zero   (alu_zero),
    .mem        (mem_bus.master),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .imm_sel    (imm_sel),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg2loc    (reg2loc),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .fault      (fault),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    instr = 32'h0;
    alu_zero = 1'b0;
    mem_bus.mem_ready = 1'b0;

    // Reset held for 3 cycles: no requests, no writes.
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_wr_en", {ir_write, pc_write, reg_write, mem_bus.mem_req}, 4'b0000);
      check("rst_misc", {illegal, fault, busy, imm_sel}, 5'b0);
    end

    // ---- ADD, zero wait: first fetch right after reset release ----
    reset = 1'b0;
    mem_bus.mem_ready = 1'b1;
    instr = I_ADD;
    #1;
    check("add_c1_req", {mem_bus.mem_req, mem_bus.mem_is_fetch, mem_bus.mem_we}, 3'b110);
    check("add_c1_ir", {ir_write, pc_write, pc_src, busy}, 4'b1100);
    cyc(); mem_bus.mem_ready = 1'b0; #1;
    check("add_c2_dec", {mem_bus.mem_req, reg_write, busy, illegal}, 4'b0010);
    cyc();
    check("add_c3_exec", {alu_src, alu_op, reg_write}, 5'b0_000_0);
    cyc();
    check("add_c4_wb", {reg_write, mem_to_reg, pc_write}, 3'b100);
    cyc();
    check("add_fetch", {mem_bus.mem_req, mem_bus.mem_is_fetch, reg_write, busy}, 4'b1100);

    // ---- LDUR with 3 wait cycles in S_MEM_RD ----
    instr = I_LDUR;
    mem_bus.mem_ready = 1'b1; #1;
    check("ld_c1_ir", ir_write, 1'b1);
    cyc(); mem_bus.mem_ready = 1'b0; #1;
    check("ld_c2_imm", imm_sel, 2'b11);
    cyc();
    check("ld_c3_addr", {alu_src, alu_op, imm_sel, reg2loc}, 7'b1_000_11_0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("ld_wait", {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_is_fetch, reg_write}, 4'b1000);
      cyc();
    end
    mem_bus.mem_ready = 1'b1; #1;
    check("ld_c7_req", {mem_bus.mem_req, mem_bus.mem_we, imm_sel}, 4'b1011);
    cyc(); mem_bus.mem_ready = 1'b0; #1;
    check("ld_c8_wb", {reg_write, mem_to_reg, mem_bus.mem_req, imm_sel}, 5'b11011);
    cyc();
    check("ld_fetch", {mem_bus.mem_req, mem_bus.mem_is_fetch, reg_write}, 3'b110);

    // ---- CBZ taken ----
    instr = I_CBZ;
    mem_bus.mem_ready = 1'b1; #1;
    cyc(); mem_bus.mem_ready = 1'b0; #1;
    check("cbz1_dec_imm", imm_sel, 2'b10);
    cyc(); alu_zero = 1'b1; #1;
    check("cbz1_br", {pc_write, pc_src, imm_sel, alu_op, reg2loc}, 8'b1_1_10_100_1);
    cyc(); alu_zero = 1'b0; #1;
    check("cbz1_fetch", {mem_bus.mem_req, pc_write, imm_sel}, 4'b1010);

    // ---- B ----
    instr = I_B;
    mem_bus.mem_ready = 1'b1; #1;
    cyc(); mem_bus.mem_ready = 1'b0; #1;
    check("b_dec_imm", imm_sel, 2'b00);
    cyc();
    check("b_jump", {pc_write, pc_src, imm_sel, reg_write}, 5'b11000);
    cyc();
    check("b_fetch", {mem_bus.mem_req, pc_write}, 2'b10);

    // ---- CBZ not taken ----
    instr = I_CBZ;
    mem_bus.mem_ready = 1'b1; #1;
    cyc(); mem_bus.mem_ready = 1'b0; #1;
    cyc(); alu_zero = 1'b0; #1;
    check("cbz0_br", {pc_write, pc_src, imm_sel}, 4'b0010);
    cyc();
    check("cbz0_hold_imm", {mem_bus.mem_req, imm_sel}, 3'b110);

    // ---- Illegal opcode ----
    instr = I_BAD;
    mem_bus.mem_ready = 1'b1; #1;
    cyc(); mem_bus.mem_ready = 1'b0; #1;
    check("ill_dec", {illegal, reg_write, pc_write}, 3'b100);
    cyc();
    check("ill_fetch", {illegal, mem_bus.mem_req, mem_bus.mem_is_fetch, busy}, 4'b0110);

    // ---- STUR with memory never ready: timeout ----
    instr = I_STUR;
    mem_bus.mem_ready = 1'b1; #1;
    cyc(); mem_bus.mem_ready = 1'b0; #1;
    cyc();
    check("st_addr", {alu_src, reg2loc, imm_sel}, 4'b1111);
    cyc();
    for (int i = 0; i < 4; i++) begin
      check("st_wait", {mem_bus.mem_req, mem_bus.mem_we, fault}, 3'b110);
      cyc();
    end
    check("st_fault", {fault, mem_bus.mem_req, reg_write, pc_write}, 4'b1000);
    cyc();
    check("st_after_fault", {fault, mem_bus.mem_req, mem_bus.mem_is_fetch, busy}, 4'b0110);

    // ---- Reset asserted mid S_MEM_WR ----
    mem_bus.mem_ready = 1'b1; #1;
    cyc(); mem_bus.mem_ready = 1'b0; #1;
    cyc();
    cyc();
    check("rst_mid_wr", {mem_bus.mem_req, mem_bus.mem_we}, 2'b11);
    reset = 1'b1;
    cyc();
    check("rst_mid_after", {mem_bus.mem_req, pc_write, reg_write, busy}, 4'b0000);
    reset = 1'b0; #1;
    check("rst_mid_fetch", {mem_bus.mem_req, mem_bus.mem_is_fetch, busy}, 3'b110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/legv8_multicycle_ctrl.md
Name: legv8_multicycle_ctrl

Overview:
- Multicycle control FSM for the LEGv8 core.
- Sequences fetch, decode, execute, memory and writeback over a shared ALU and a single memory port.
- Drives all datapath enables, including imm_sel for the sign-extend unit and the branch/PC mux.
- Sits between the instruction register and the datapath.
- Owns the memory request/ready handshake.

Parameters:
- MEM_TIMEOUT, 255, max cycles waiting on mem_ready before the FSM raises fault and returns to S_FETCH (0 disables the timeout).

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- instr  in  32  current instruction-register contents
- alu_zero  in  1  ALU zero flag (valid in S_BRANCH)
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write (STUR), 0 = read
- mem_is_fetch  out  1  request targets the PC address (fetch)
- ir_write  out  1  load instruction register from memory data
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = PC+(imm<<2)
- imm_sel  out  2  sign-extend format: 00 B-type, 10 CB-type, 11 D-type
- alu_src  out  1  0 = register, 1 = extended immediate
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 PASS-B
- reg2loc  out  1  read-register-2 select: 1 = Rt (STUR/CBZ)
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback source: 1 = memory data
- illegal  out  1  one-cycle pulse on an undecodable instruction
- fault  out  1  one-cycle pulse on memory timeout
- busy  out  1  high in every state except S_FETCH awaiting the first request

Behaviour:
- Reset (sync, active-high) enters S_FETCH with timeout counter 0. All outputs are 0 during and in the cycle after reset, except mem_req and mem_is_fetch, which assert in the first S_FETCH cycle.
- Reset asserted mid-operation aborts the transaction: mem_req drops on the next edge and no pc_write or reg_write is issued.
- Decode fields:
  - R-type: instr[31:21] 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR.
  - D-type: 11111000010 LDUR, 11111000000 STUR.
  - CB-type: instr[31:24] 10110100 CBZ.
  - B-type: instr[31:26] 000101 B.
- States and transitions:
  - S_FETCH: mem_req=1, mem_is_fetch=1. Hold until mem_ready; then ir_write=1, pc_write=1, pc_src=0, go to S_DECODE.
  - S_DECODE: one cycle; register read; imm_sel set from opcode.
    - R-type -> S_EXEC_R.
    - LDUR/STUR -> S_ADDR.
    - CBZ -> S_BRANCH.
    - B -> S_JUMP.
    - Otherwise illegal=1 -> S_FETCH.
  - S_EXEC_R: alu_src=0, alu_op per opcode -> S_WB_R.
  - S_WB_R: reg_write=1, mem_to_reg=0 -> S_FETCH.
  - S_ADDR: alu_src=1, alu_op=ADD, imm_sel=11, reg2loc=1 for STUR. Go to S_MEM_RD (LDUR) or S_MEM_WR (STUR).
  - S_MEM_RD / S_MEM_WR: mem_req=1, mem_we=1 only in S_MEM_WR. Hold until mem_ready. Then S_MEM_RD -> S_WB_LD; S_MEM_WR -> S_FETCH.
  - S_WB_LD: reg_write=1, mem_to_reg=1 -> S_FETCH.
  - S_BRANCH: reg2loc=1, alu_op=PASS-B, imm_sel=10. If alu_zero: pc_write=1, pc_src=1. -> S_FETCH.
  - S_JUMP: imm_sel=00, pc_write=1, pc_src=1 -> S_FETCH.
- Handshake:
  - mem_req stays high and address/control stay stable until the cycle mem_ready is sampled high.
  - mem_ready while mem_req=0 is ignored.
  - mem_ready in the first request cycle gives zero wait states.
- PC update for taken branches uses the fetch-time PC; the datapath keeps an old_pc register written when ir_write=1.
- Timeout: a counter increments each waiting cycle and clears on mem_ready or state exit. At MEM_TIMEOUT: fault=1, mem_req drops, next state S_FETCH, no writes.
- Latency at zero wait states:
  - R-type 4 cycles; LDUR 5; STUR 4; CBZ 3; B 3.
  - Each memory wait adds 1 cycle.
- imm_sel holds its last value outside S_DECODE, S_ADDR, S_BRANCH and S_JUMP, so there are no spurious changes.

Decomposition:
- Package legv8_ctrl_pkg:
  - state enum
  - opcode constants (OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ, OP_B)
  - alu_op codes
  - IMM_B/IMM_CB/IMM_D encodings, shared with the sign-extend unit
- One sub-module, legv8_opdecode: combinational instr -> {class, alu_op, imm_sel, legal}.
- The FSM, handshake and timeout counter stay in the top.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1: first cycle mem_req=1, mem_is_fetch=1; all write enables 0 during reset.
- ADD X1,X2,X3 (0x8B030041), zero-wait: ir_write at cycle 1, alu_op=000 in S_EXEC_R, reg_write=1 exactly at cycle 4, then fetch.
- LDUR (0xF8408041) with mem_ready delayed 3 cycles in S_MEM_RD: mem_req held 4 cycles, mem_we=0, imm_sel=11, reg_write+mem_to_reg at cycle 8.
- CBZ (0xB4000060) run twice: with alu_zero=1, pc_write=1 and pc_src=1 in S_BRANCH; with alu_zero=0, pc_write=0. imm_sel=10 in both runs.
- Opcode 0xFFFFFFFF: illegal pulses 1 cycle in S_DECODE, no reg_write/pc_write, FSM back in S_FETCH next cycle.
- MEM_TIMEOUT=4, mem_ready held 0 during STUR: fault pulses after 4 wait cycles, mem_req drops, no reg_write. Separately, reset mid-S_MEM_WR leaves mem_req=0 on the next edge.
